multi_channel_divider: RTL and testbench

Parametrised successor to the single-rate LED counter: `CHANNELS` independent clock-enable/blink generators sharing one clock. Each channel has a run-time programmable period and mode (50 % square toggle or one-cycle strobe). Channels can be phase-aligned with a global sync pulse. The block sits between the debounced button / control logic and the LED and debug pins, replacing fixed-frequency counter instances.

---
 rtl/multi_channel_divider.sv | 110 +++++++++++
 tb/tb_multi_channel_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_divider.sv
// multi_channel_divider
//
// A bank of CHANNELS independent clock-enable / blink generators sharing one
// clock. Each channel has a run-time programmable period P and mode:
//   mode 0 (toggle): out_sig is a square wave of frequency f_clk/(2P)
//   mode 1 (pulse) : out_sig is a one-cycle strobe every P cycles
// A period of 0 disables the channel. in_sync restarts every channel at
// phase 0 without touching its configuration.
//
// Ports
//   in_clk        system clock, rising edge
//   in_rst_n      asynchronous active-low reset
//   in_sync       single-cycle request restarting all channels at phase 0
//   in_wr_en      configuration write strobe
//   in_wr_ch      channel index for the write (out-of-range index ignored)
//   in_wr_period  new period P in cycles (0 disables the channel)
//   in_wr_mode    0 = toggle, 1 = pulse
//   out_sig       per-channel registered output
//   out_wrap      per-channel registered one-cycle strobe on counter wrap
module multi_channel_divider #(
  parameter int              CHANNELS   = 4,
  parameter int              CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = 27000000,
  localparam int             CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                in_sync,
  input  logic                in_wr_en,
  input  logic [CH_W-1:0]     in_wr_ch,
  input  logic [CNT_W-1:0]    in_wr_period,
  input  logic                in_wr_mode,
  output logic [CHANNELS-1:0] out_sig,
  output logic [CHANNELS-1:0] out_wrap
);

  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CNT_W-1:0]    period_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d;
  logic [CHANNELS-1:0] wr_sel;

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    wr_sel = '0;
    mode_d = mode_q;
    sig_d  = sig_q;
    wrap_d = wrap_q;
    for (int i = 0; i < CHANNELS; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];

      // An index >= CHANNELS matches no channel, so such writes vanish.
      wr_sel[i] = in_wr_en && (in_wr_ch == CH_W'(i));

      if (wr_sel[i]) begin
        period_d[i] = in_wr_period;
        mode_d[i]   = in_wr_mode;
      end

      if (wr_sel[i] || in_sync || (period_q[i] == '0)) begin
        // Restart (write or sync) or disabled channel: everything at phase 0.
        cnt_d[i]  = '0;
        sig_d[i]  = 1'b0;
        wrap_d[i] = 1'b0;
      end else if (cnt_q[i] == period_q[i] - CNT_W'(1)) begin
        // cnt < period always holds, so this compare never sees P = 0.
        cnt_d[i]  = '0;
        wrap_d[i] = 1'b1;
        sig_d[i]  = mode_q[i] ? 1'b1 : ~sig_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        wrap_d[i] = 1'b0;
        if (mode_q[i]) sig_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      // NOTE: the per-channel arrays are configuration registers, not a RAM,
      // so they are reset like any other flop; defaults must be live at once.
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= DEF_PERIOD;
        cnt_q[i]    <= '0;
      end
      mode_q <= '0;
      sig_q  <= '0;
      wrap_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      mode_q <= mode_d;
      sig_q  <= sig_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_sig  = sig_q;
  assign out_wrap = wrap_q;

endmodule

// File: tb/tb_multi_channel_divider.sv
// Testbench for multi_channel_divider.
// Main instance: CHANNELS=2, CNT_W=8, DEF_PERIOD=4. A second 3-channel
// instance exists because a 2-channel index bus (1 bit) cannot express an
// out-of-range channel such as 3.
module tb_multi_channel_divider;

  localparam int CNT_W = 8;
  localparam int NM    = 5;  // model channels: 0..1 main DUT, 2..4 the 3-ch DUT

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             sync = 1'b0;
  logic             wr_en = 1'b0, wr_mode = 1'b0;
  logic             wr_ch = 1'b0;
  logic [CNT_W-1:0] wr_period = '0;
  logic             wr3_en = 1'b0, wr3_mode = 1'b0;
  logic [1:0]       wr3_ch = '0;
  logic [CNT_W-1:0] wr3_period = '0;
  logic [1:0]       sig, wrap;
  logic [2:0]       sig3, wrap3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_channel_divider #(.CHANNELS(2), .CNT_W(CNT_W), .DEF_PERIOD(8'd4)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_sync(sync),
    .in_wr_en(wr_en), .in_wr_ch(wr_ch), .in_wr_period(wr_period), .in_wr_mode(wr_mode),
    .out_sig(sig), .out_wrap(wrap)
  );

  multi_channel_divider #(.CHANNELS(3), .CNT_W(CNT_W), .DEF_PERIOD(8'd4)) dut3 (
    .in_clk(clk), .in_rst_n(rst_n), .in_sync(sync),
    .in_wr_en(wr3_en), .in_wr_ch(wr3_ch), .in_wr_period(wr3_period), .in_wr_mode(wr3_mode),
    .out_sig(sig3), .out_wrap(wrap3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel only remembers its config and the number
  // of edges t since its last restart. Outputs follow from plain arithmetic:
  // wrap when t is a positive multiple of P; toggle output is the parity of
  // completed periods; pulse output equals wrap.
  int m_period [NM];
  bit m_mode   [NM];
  int m_t      [NM];
  bit hit;

  function automatic bit exp_wrap(int i);
    return (m_period[i] != 0) && (m_t[i] > 0) && ((m_t[i] % m_period[i]) == 0);
  endfunction

  function automatic bit exp_sig(int i);
    if (m_period[i] == 0) return 1'b0;
    if (m_mode[i]) return exp_wrap(i);
    return ((m_t[i] / m_period[i]) % 2) == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NM; i++) begin
        m_period[i] = 4;
        m_mode[i]   = 1'b0;
        m_t[i]      = 0;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (i < 2) hit = wr_en && (int'(wr_ch) == i);
        else       hit = wr3_en && (int'(wr3_ch) == i - 2);
        if (hit) begin
          m_period[i] = (i < 2) ? int'(wr_period) : int'(wr3_period);
          m_mode[i]   = (i < 2) ? wr_mode : wr3_mode;
        end
        if (hit || sync) m_t[i] = 0;
        else             m_t[i]++;
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model.
  always @(negedge clk) begin
    logic [1:0] es, ew;
    logic [2:0] es3, ew3;
    for (int i = 0; i < 2; i++) begin
      es[i] = exp_sig(i);
      ew[i] = exp_wrap(i);
    end
    for (int i = 0; i < 3; i++) begin
      es3[i] = exp_sig(i + 2);
      ew3[i] = exp_wrap(i + 2);
    end
    check("model_sig", sig, es);
    check("model_wrap", wrap, ew);
    check("model_sig3", sig3, es3);
    check("model_wrap3", wrap3, ew3);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    check("reset_sig", sig, 2'b00);
    check("reset_wrap", wrap, 2'b00);
    rst_n = 1'b1;

    // 1: default period 4, toggle
    tick(3); check("s1_e3_sig", sig, 2'b00);
    tick(1); check("s1_e4_sig", sig, 2'b11); check("s1_e4_wrap", wrap, 2'b11);
    tick(1); check("s1_e5_sig", sig, 2'b11); check("s1_e5_wrap", wrap, 2'b00);
    tick(3); check("s1_e8_sig", sig, 2'b00); check("s1_e8_wrap", wrap, 2'b11);
    tick(1);

    // 2: ch1 P=3 pulse written at edge 10
    wr_en = 1'b1; wr_ch = 1'b1; wr_period = 8'd3; wr_mode = 1'b1;
    tick(1); wr_en = 1'b0;
    check("s2_e10_sig", sig, 2'b00);
    tick(2); check("s2_e12_sig", sig, 2'b01);
    tick(1); check("s2_e13_sig", sig, 2'b11); check("s2_e13_wrap", wrap, 2'b10);
    tick(1); check("s2_e14_sig", sig, 2'b01);
    tick(2); check("s2_e16_sig", sig, 2'b10); check("s2_e16_wrap", wrap, 2'b11);
    tick(3); check("s2_e19_sig", sig, 2'b10);

    // 3: ch0 disabled, then P=1 toggle
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd0; wr_mode = 1'b0;
    tick(1); wr_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      check("s3_disabled_ch0", {sig[0], wrap[0]}, 2'b00);
    end
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd1; wr_mode = 1'b0;
    tick(1); wr_en = 1'b0;
    check("s3_p1_w0", sig[0], 1'b0);
    tick(1); check("s3_p1_w1", sig[0], 1'b1);
    tick(1); check("s3_p1_w2", sig[0], 1'b0);
    tick(1); check("s3_p1_w3", sig[0], 1'b1);

    // 4: ch0 P=4 and ch1 P=3 toggle, out of phase, then a sync pulse
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd4; wr_mode = 1'b0;
    tick(1);
    wr_ch = 1'b1; wr_period = 8'd3;
    tick(1); wr_en = 1'b0;
    tick(5);
    sync = 1'b1; tick(1); sync = 1'b0;
    check("s4_sync_sig", sig, 2'b00); check("s4_sync_wrap", wrap, 2'b00);
    tick(2); check("s4_e2_sig", sig, 2'b00);
    tick(1); check("s4_e3_sig", sig, 2'b10);
    tick(1); check("s4_e4_sig", sig, 2'b11);
    // sync held high: everything pinned at 0
    tick(1);
    sync = 1'b1; tick(3);
    check("s4_held_sig", sig, 2'b00); check("s4_held_sig3", sig3, 3'b000);
    sync = 1'b0; tick(1);
    check("s4_release_sig", sig, 2'b00);

    // 5: sync + write ch1 P=2 on one edge; out-of-range write on the 3-ch DUT
    sync = 1'b1; wr_en = 1'b1; wr_ch = 1'b1; wr_period = 8'd2; wr_mode = 1'b0;
    tick(1); sync = 1'b0; wr_en = 1'b0;
    check("s5_s0_sig", sig, 2'b00);
    wr3_en = 1'b1; wr3_ch = 2'd3; wr3_period = 8'd2; wr3_mode = 1'b1;
    tick(1); wr3_en = 1'b0;
    check("s5_s1_sig", sig, 2'b00);
    tick(1); check("s5_s2_sig", sig, 2'b10); check("s5_s2_wrap", wrap, 2'b10);
    check("s5_s2_sig3", sig3, 3'b000);
    tick(2); check("s5_s4_sig", sig, 2'b01); check("s5_s4_wrap", wrap, 2'b11);
    check("s5_s4_sig3", sig3, 3'b111); check("s5_s4_wrap3", wrap3, 3'b111);

    // 6: asynchronous reset mid-period, then defaults
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_sig", sig, 2'b00); check("s6_async_wrap", wrap, 2'b00);
    check("s6_async_sig3", sig3, 3'b000);
    tick(2); rst_n = 1'b1;
    tick(2); check("s6_e2_sig", sig, 2'b00);
    tick(2); check("s6_e4_sig", sig, 2'b11); check("s6_e4_wrap", wrap, 2'b11);
    check("s6_e4_sig3", sig3, 3'b111);
    tick(4); check("s6_e8_sig", sig, 2'b00); check("s6_e8_wrap", wrap, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
